// File: rtl/fpnew_iter_div_lane_pkg.sv
// Shared definitions for the iterative radix-2 division lane.
// Latency: n/a (types, constants and a pure classification function only).
// Backpressure: n/a.
package fpnew_iter_div_lane_pkg;

  // Mantissa width of the single-precision divide core.
  localparam int unsigned DIV_DEFAULT_WIDTH = 24;

  // How a start request is handled: iterated, or answered in the start cycle.
  typedef enum logic [1:0] {
    CASE_NORMAL,
    CASE_INACTIVE,
    CASE_DIV_ZERO
  } div_case_e;

  // An inactive lane wins over a zero divisor: it must never raise div_zero.
  function automatic div_case_e classify_start(input logic lane_active,
                                               input logic divisor_zero);
    if (!lane_active) begin
      return CASE_INACTIVE;
    end
    if (divisor_zero) begin
      return CASE_DIV_ZERO;
    end
    return CASE_NORMAL;
  endfunction

endpackage

// File: rtl/fpnew_iter_div_lane.sv
// Unsigned WIDTH-bit restoring divider lane (quotient + remainder), one bit per cycle.
// Latency: WIDTH+1 cycles start-to-ready; inactive lane / zero divisor answer in the start cycle.
// Backpressure: none needed; results are held in DONE until the next start, ready_o is a level.
module fpnew_iter_div_lane
  import fpnew_iter_div_lane_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             lane_active_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;    // partial remainder R
  logic [WIDTH-1:0] quo_q, quo_d;    // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] div_q, div_d;    // divisor D
  logic             dz_q, dz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  div_case_e        start_case;
  logic             start_ok;
  logic             fast_start;
  logic             norm_start;
  logic [WIDTH-1:0] fast_quo;
  logic [WIDTH-1:0] fast_rem;
  logic             fast_dz;

  logic [WIDTH:0]   step_t;
  logic [WIDTH:0]   step_diff;
  logic             step_ge;
  logic [WIDTH:0]   step_rem;
  logic [WIDTH-1:0] step_quo;

  // A start while iterating is ignored, so it must not disturb ready_o or the outputs either.
  assign start_case = classify_start(lane_active_i, divisor_i == '0);
  assign start_ok   = start_i && (state_q != RUN);
  assign fast_start = start_ok && (start_case != CASE_NORMAL);
  assign norm_start = start_ok && (start_case == CASE_NORMAL);

  // Result of a start that completes immediately (inactive lane or zero divisor).
  always_comb begin
    fast_quo = '0;
    fast_rem = '0;
    fast_dz  = 1'b0;
    if (start_case == CASE_DIV_ZERO) begin
      fast_quo = '1;
      fast_rem = dividend_i;
      fast_dz  = 1'b1;
    end
  end

  // One restoring step: shift the next dividend bit into R, subtract D if it fits.
  // R's top bit is never set after a legal step; if it were, T would exceed any D,
  // so it is folded into the compare rather than silently dropped.
  always_comb begin
    step_t    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    step_diff = step_t - {1'b0, div_q};
    step_ge   = rem_q[WIDTH] || (step_t >= {1'b0, div_q});
    step_rem  = step_ge ? step_diff : step_t;
    step_quo  = {quo_q[WIDTH-2:0], step_ge};
  end

  // Next-state and datapath load/step selection; flush overrides everything and keeps the data.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    dz_d    = dz_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (fast_start) begin
          state_d = DONE;
          quo_d   = fast_quo;
          rem_d   = {1'b0, fast_rem};
          dz_d    = fast_dz;
        end else if (norm_start) begin
          state_d = RUN;
          rem_d   = '0;
          quo_d   = dividend_i;
          div_d   = divisor_i;
          dz_d    = 1'b0;
          cnt_d   = CW'(WIDTH - 1);
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      dz_d    = dz_q;
      cnt_d   = cnt_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      dz_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs: fast results bypass the registers; a normal start hides the old result at once.
  always_comb begin
    busy_o      = (state_q == RUN);
    ready_o     = (state_q != RUN);
    quotient_o  = quo_q;
    remainder_o = rem_q[WIDTH-1:0];
    div_zero_o  = dz_q;
    if (fast_start) begin
      ready_o     = 1'b1;
      quotient_o  = fast_quo;
      remainder_o = fast_rem;
      div_zero_o  = fast_dz;
    end else if (norm_start) begin
      ready_o = 1'b0;
    end
  end

`ifndef SYNTHESIS
  // The opgroup FSM never restarts a lane that is still iterating.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(start_i && state_q == RUN))
    else $error("fpnew_iter_div_lane: start_i asserted while iterating");
`endif

endmodule

// File: tb/tb_fpnew_iter_div_lane.sv
module tb_fpnew_iter_div_lane;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic         lane_active_i;
  logic [W-1:0] dividend_i;
  logic [W-1:0] divisor_i;
  logic         flush_i;
  logic         ready_o;
  logic [W-1:0] quotient_o;
  logic [W-1:0] remainder_o;
  logic         div_zero_o;
  logic         busy_o;

  fpnew_iter_div_lane #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .lane_active_i(lane_active_i),
    .dividend_i   (dividend_i),
    .divisor_i    (divisor_i),
    .flush_i      (flush_i),
    .ready_o      (ready_o),
    .quotient_o   (quotient_o),
    .remainder_o  (remainder_o),
    .div_zero_o   (div_zero_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    bit           chk_data;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int           cyc = 0;
  int           start_cyc = 0;
  bit           busy_prev = 1'b0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_dz = 1'b0;
  bit           hold_ok = 1'b1;

  task automatic do_event(input bit exp_rdy, input int lat);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_completion: got a completion, expected none at %0t", $time);
    end else begin
      errors = errors;
      e = sb.pop_front();
      chk("ready_at_done", 32'(ready_o), 32'(exp_rdy));
      chk("latency", 32'(lat), 32'(e.lat));
      if (e.chk_data) begin
        chk("quotient", 32'(quotient_o), 32'(e.q));
        chk("remainder", 32'(remainder_o), 32'(e.r));
        chk("div_zero", 32'(div_zero_o), 32'(e.dz));
      end
      last_q  = e.q;
      last_r  = e.r;
      last_dz = e.dz;
      hold_ok = e.chk_data;
    end
  endtask

  always @(negedge clk_i) begin
    bit spec_now, norm_now, fell;
    if (!rst_ni) begin
      busy_prev = 1'b0;
      last_q    = '0;
      last_r    = '0;
      last_dz   = 1'b0;
      hold_ok   = 1'b1;
    end else begin
      cyc++;
      spec_now = start_i && (!lane_active_i || divisor_i == '0);
      norm_now = start_i && !spec_now;
      fell     = busy_prev && !busy_o;
      if (fell) do_event(!norm_now, cyc - start_cyc);
      if (spec_now) do_event(1'b1, 0);
      if (norm_now) chk("ready_low_on_start", 32'(ready_o), 32'd0);
      if (!start_i && !busy_o && !fell) begin
        chk("ready_hold", 32'(ready_o), 32'd1);
        if (hold_ok) begin
          chk("quotient_hold", 32'(quotient_o), 32'(last_q));
          chk("remainder_hold", 32'(remainder_o), 32'(last_r));
          chk("div_zero_hold", 32'(div_zero_o), 32'(last_dz));
        end
      end
      if (start_i) start_cyc = cyc;
      busy_prev = busy_o;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Drives a one-cycle start in the current cycle; returns at the drive point of the next cycle.
  task automatic issue(input logic act, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                       input bit chk_data, input int lat);
    exp_t e;
    e.q = eq; e.r = er; e.dz = edz; e.chk_data = chk_data; e.lat = lat;
    sb.push_back(e);
    start_i       = 1'b1;
    lane_active_i = act;
    dividend_i    = a;
    divisor_i     = b;
    step(1);
    start_i       = 1'b0;
    lane_active_i = 1'b0;
    dividend_i    = '0;
    divisor_i     = '0;
  endtask

  task automatic model(input logic act, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                       output int lat);
    if (!act) begin
      q = '0; r = '0; dz = 1'b0; lat = 0;
    end else if (b == '0) begin
      q = '1; r = a; dz = 1'b1; lat = 0;
    end else begin
      q = a / b; r = a % b; dz = 1'b0; lat = W + 1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(ready_o), 32'd1);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient_o), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder_o), 32'd0);
    chk({tag, "_div_zero"}, 32'(div_zero_o), 32'd0);
  endtask

  initial begin
    logic         act;
    logic [W-1:0] a, b, eq, er;
    logic         edz;
    int           lat;
    bit           nrm, pend_norm;
    int           guard;

    rst_ni        = 1'b0;
    start_i       = 1'b0;
    lane_active_i = 1'b0;
    dividend_i    = '0;
    divisor_i     = '0;
    flush_i       = 1'b0;
    #12;
    check_reset_values("reset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step(1);

    // Normal divide, then 20 idle cycles of hold.
    issue(1'b1, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1, 9);
    step(8 + 20);

    // Divide by zero and inactive lane complete in the start cycle.
    issue(1'b1, 8'd93, 8'd0, 8'hFF, 8'd93, 1'b1, 1'b1, 0);
    step(3);
    issue(1'b0, 8'd5, 8'd3, 8'd0, 8'd0, 1'b0, 1'b1, 0);
    step(3);

    // Back-to-back: second start in the first DONE cycle.
    issue(1'b1, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, 9);
    step(8);
    issue(1'b1, 8'd17, 8'd5, 8'd3, 8'd2, 1'b0, 1'b1, 9);
    step(8 + 3);

    // Flush in cycle t0+4: lane returns to IDLE one cycle later, data not checked.
    issue(1'b1, 8'd100, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0, 5);
    step(3);
    flush_i = 1'b1;
    step(1);
    flush_i = 1'b0;
    step(2);
    issue(1'b1, 8'd9, 8'd4, 8'd2, 8'd1, 1'b0, 1'b1, 9);
    step(12);

    // Asynchronous reset in the middle of an iteration, between clock edges.
    issue(1'b1, 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1, 9);
    step(2);
    #2;
    rst_ni = 1'b0;
    sb.delete();
    #1;
    check_reset_values("async_reset");
    step(2);
    rst_ni = 1'b1;
    step(2);

    // Random regression against the reference model.
    pend_norm = 1'b0;
    for (int n = 0; n < 500; n++) begin
      act = ($urandom_range(0, 15) != 0);
      a   = W'($urandom_range(0, 255));
      b   = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      nrm = act && (b != '0);
      if (pend_norm) begin
        step(W);
        if (!(nrm && ($urandom_range(0, 1) == 1))) step(1);
      end else begin
        step(int'($urandom_range(0, 2)));
      end
      model(act, a, b, eq, er, edz, lat);
      issue(act, a, b, eq, er, edz, 1'b1, lat);
      pend_norm = nrm;
    end

    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      step(1);
      guard++;
    end
    step(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpnew_iter_div_lane.md
# fpnew_iter_div_lane

Iterative radix-2 restoring division lane for one SIMD slot of an FPNew multi-cycle opgroup. It is started by the opgroup's shared aux/handshake FSM via a one-cycle start pulse and signals completion through a level `ready_o`. Results are held stable until the next start, so the aux FSM can stall its output pipeline indefinitely. It computes an unsigned WIDTH-bit quotient and remainder (mantissa divide core). Divide-by-zero and inactive lanes complete in the start cycle.

## Interface
- `WIDTH`, default 24: operand, quotient and remainder width; must be ≥ 2.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  one-cycle start pulse; operands are sampled in this cycle.
- `lane_active_i`  in  1  lane carries valid data for this operation; sampled with `start_i`.
- `dividend_i`  in  WIDTH  unsigned dividend.
- `divisor_i`  in  WIDTH  unsigned divisor.
- `flush_i`  in  1  synchronous abort.
- `ready_o`  out  1  result valid and stable.
- `quotient_o`  out  WIDTH  quotient.
- `remainder_o`  out  WIDTH  remainder.
- `div_zero_o`  out  1  divisor was zero on an active lane.
- `busy_o`  out  1  iteration in progress.

## Operation
- **States:** IDLE, RUN, DONE. Iteration counter is $clog2(WIDTH) bits.
- **Registers:**
  - partial remainder R: WIDTH+1 bits
  - shift register Q: WIDTH bits; holds the dividend at load, the quotient at end
  - divisor register D: WIDTH bits
  - div-zero flag
- **Special case (fast path).** When `start_i`=1 and either `lane_active_i`=0 or `divisor_i`=0:
  - State goes to DONE.
  - `ready_o`=1 combinationally in the same cycle.
  - Outputs are bypassed combinationally in the same cycle and also registered:
    - inactive lane: quotient 0, remainder 0, `div_zero_o` 0
    - zero divisor: quotient all-ones, remainder = dividend, `div_zero_o` 1
- **Normal start.** When `start_i`=1 in IDLE or DONE and the operands are not a special case:
  - Load R=0, Q=dividend, D=divisor, counter=WIDTH-1; go to RUN.
  - `ready_o` is forced to 0 in this cycle, even when coming from DONE.
- **RUN step, each cycle:**
  - T={R[WIDTH-1:0],Q[WIDTH-1]}
  - If T ≥ {0,D}: R=T−D, qbit=1. Otherwise R=T, qbit=0.
  - Q={Q[WIDTH-2:0],qbit}
  - Counter decrements. The step taken at counter 0 moves the state to DONE.
- **DONE:**
  - `quotient_o`=Q, `remainder_o`=R[WIDTH-1:0], `ready_o`=1.
  - Values are held until the next `start_i`.
- **IDLE:** `ready_o`=1, outputs show the last registered values (0 after reset).
- **Illegal start:** `start_i` during RUN is illegal (the aux FSM guarantees it never happens). It is ignored and flagged by an assertion.
- **Flush:**
  - `flush_i`=1 sends the state to IDLE next cycle from any state.
  - Flush has priority over a simultaneous `start_i`: no load, and the fast-path `ready_o` bypass is still allowed combinationally.
  - Data registers are not cleared.
- **Outputs:** `busy_o`=1 exactly in RUN.

## Timing
- **Reset values:**
  - state IDLE
  - `ready_o`=1, `busy_o`=0
  - `quotient_o`=0, `remainder_o`=0, `div_zero_o`=0
- **Normal latency:** start at cycle t0 → RUN during t0+1…t0+WIDTH → `ready_o` rises at t0+WIDTH+1.
- **Fast-path latency:** 0 cycles (`ready_o` in t0).
- **Back-to-back:** a start in the first DONE cycle is legal; `ready_o` drops in that same cycle.
- **Combinational paths:** `ready_o` and the result outputs depend combinationally on `start_i`, `lane_active_i`, `divisor_i` and `dividend_i` only. No path exists from any output back to any input.
- **Reset mid-RUN:** asynchronously returns to the reset values.

## Structure
- The state enum is local to the module. No new types go into `fpnew_pkg`.
- No sub-module. The single restoring step is a local combinational block.
- The opgroup block instantiates one lane per SIMD slot:
  - `start_i` driven by the aux FSM's `fsm_start_o`
  - aux FSM `fsm_ready_i` = AND of all lane `ready_o`

## Test plan
- **Normal divide, WIDTH=8.** Reset, then start with 200/7 → `ready_o` low for 8 cycles, high at t0+9 with quotient 28, remainder 4, `div_zero_o` 0; values hold for 20 idle cycles.
- **Divide by zero.** Start with 93/0 → same-cycle `ready_o`=1, quotient 0xFF, remainder 93, `div_zero_o` 1; state DONE, `busy_o` 0.
- **Inactive lane.** Start with `lane_active_i`=0 and 5/3 → same-cycle `ready_o`=1, quotient 0, remainder 0.
- **Back-to-back.** Start 255/1; in its first DONE cycle start 17/5 → `ready_o` drops in that cycle; next result quotient 3, remainder 2 at +9 cycles.
- **Flush.** Flush at t0+4 during 100/3 → IDLE next cycle, `busy_o` 0, `ready_o` 1; a following 9/4 yields quotient 2, remainder 1.
- **Asynchronous reset.** Assert `rst_ni` low mid-RUN between clock edges → outputs reach reset values immediately; a random 500-op regression against a reference model shows no mismatch.
